axi3_mem_responder: RTL and testbench
=====================================

Name: axi3_mem_responder

Overview:
- AXI3 slave memory model that answers a bank's BIU master port: accepts AR/AW/W, returns R/B with 256-bit data beats.
- Sits on each bankN_biu_axi3_* port in place of the external DRAM controller for synthesis and bring-up.
- Handles one transaction at a time and serializes reads and writes through a single FSM.
- Storage is a flop array of 2**DEPTH_LOG2 words of 256 bits.

Parameters:
DEPTH_LOG2, 8, log2 of memory depth in 32-byte words
RD_ERR_DATA, 256'h0, rdata returned on SLVERR read beats

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
axi3_arvalid_i  in  1  read address valid
axi3_arready_o  out  1  read address ready
axi3_arid_i  in  8  read ID
axi3_araddr_i  in  32  read byte address
axi3_arsize_i  in  3  beat size
axi3_arlen_i  in  4  beats minus one
axi3_arburst_i  in  2  burst type
axi3_rvalid_o  out  1  read data valid
axi3_rready_i  in  1  read data ready
axi3_rid_o  out  8  read ID echo
axi3_rdata_o  out  256  read data
axi3_rresp_o  out  2  read response
axi3_rlast_o  out  1  last read beat
axi3_awvalid_i  in  1  write address valid
axi3_awready_o  out  1  write address ready
axi3_awaddr_i  in  32  write byte address
axi3_awlen_i  in  4  beats minus one
axi3_awsize_i  in  3  beat size
axi3_awburst_i  in  2  burst type
axi3_wid_i  in  8  write ID
axi3_wvalid_i  in  1  write data valid
axi3_wready_o  out  1  write data ready
axi3_wdata_i  in  256  write data
axi3_wstrb_i  in  32  byte enables
axi3_wlast_i  in  1  last write beat
axi3_bvalid_o  out  1  write response valid
axi3_bready_i  in  1  write response ready
axi3_bid_o  out  8  write response ID
axi3_bresp_o  out  2  write response

Behaviour:
Clock and reset:
- One clock, clk_i.
- rst_i is asynchronous and active-low.
- While rst_i=0: FSM=IDLE; all ready/valid/last outputs 0; rid/bid/rresp/bresp 0; rdata 0; beat counter 0; priority bit = read-first.
- Memory contents are not reset.
- Reset asserted mid-burst abandons the transaction; no further beats or responses are issued for it.

FSM: IDLE, RD, WR, WRESP.
- IDLE:
  - arready = arvalid & ~(awvalid & pri_wr); awready = awvalid & ~(arvalid & ~pri_wr).
  - These are combinational from state, valids and pri_wr.
  - On an AR handshake: capture id, word address, len and error flag, then go to RD. pri_wr <= 1.
  - On an AW handshake: capture address, len and error flag, then go to WR. pri_wr <= 0.
  - Exactly one handshake can occur per cycle.
- RD:
  - rvalid=1 starting the cycle after the AR handshake.
  - rdata = mem[idx], or RD_ERR_DATA on error.
  - rlast = (cnt==len).
  - rdata, rid, rresp and rlast are held stable while rready=0.
  - Each handshake increments cnt; beats can complete every cycle.
  - On the handshake with rlast: go to IDLE, cnt <= 0.
- WR:
  - wready=1 starting the cycle after the AW handshake.
  - Each beat writes the bytes of mem[idx] enabled by wstrb; no write is performed when the error flag is set.
  - bid is captured from wid on the first beat.
  - The burst ends at the beat carrying wlast, then go to WRESP.
  - If the beat count != len+1, bresp is SLVERR. Beats beyond len+1 without wlast are accepted but not written.
- WRESP:
  - bvalid=1 the cycle after the wlast beat; held until bready.
  - Then go to IDLE.

Addressing:
- Word index = addr[DEPTH_LOG2+4:5].
- Upper address bits are ignored (aliasing); addr[4:0] is ignored.
- INCR (2'b01): idx+1 per beat, modulo 2**DEPTH_LOG2 (wraps at the top of memory).
- FIXED (2'b00): idx is constant.
- Error flag is set when burst = WRAP (2'b10) or reserved (2'b11), or when size != 3'b101. The error flag gives resp SLVERR (2'b10) on all beats; otherwise OKAY (2'b00).

Latency and throughput:
- Read: AR handshake at cycle N gives the first rvalid at N+1; a len-L burst with rready held high finishes at N+1+L.
- Write: the wlast beat at cycle M gives bvalid at M+1.
- A new AR/AW can be accepted in the cycle after the final R or B handshake.

Test Plan:
- Reset: rst_i=0 with random inputs -> all valids/readies 0. Release reset with arvalid=1 -> arready=1 the same cycle.
- INCR write then read: AW addr=0x40 len=3 with beats D0..D3, wstrb all 1s, wid=0x5A -> bid=0x5A, bresp=0. Then AR addr=0x40 len=3 id=0x11 -> rdata D0..D3 on consecutive cycles, rlast on beat 3, rid=0x11.
- Partial strobe and FIXED: write addr=0x20 with wstrb=32'h0000_000F, burst FIXED, len=1 -> only bytes 0-3 of word 1 change, holding the second beat's value. Read back confirms.
- Wrap-around and backpressure: INCR read at idx 255 len=1 (DEPTH_LOG2=8) returns mem[255], mem[0]. Toggle rready 0/1 -> outputs stable while rready=0, no beat lost.
- Errors: arsize=3'b100 -> every beat rresp=2'b10 with rdata=RD_ERR_DATA. Write with awlen=3 but wlast on beat 1 -> bresp=2'b10.
- Arbitration and reset mid-op: arvalid and awvalid both high at once -> read granted first, then write. Assert rst_i=0 mid read burst -> rvalid drops immediately and the FSM is IDLE after release.

Source files
------------

// File: rtl/axi3_mem_responder.sv
// AXI3 slave memory model: serves one read or write burst at a time from a
// flop array of 256-bit words, with alternating read/write priority in IDLE.
module axi3_mem_responder #(
    parameter int           DEPTH_LOG2  = 8,
    parameter logic [255:0] RD_ERR_DATA = 256'h0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         axi3_arvalid_i,
    output logic         axi3_arready_o,
    input  logic [7:0]   axi3_arid_i,
    input  logic [31:0]  axi3_araddr_i,
    input  logic [2:0]   axi3_arsize_i,
    input  logic [3:0]   axi3_arlen_i,
    input  logic [1:0]   axi3_arburst_i,
    output logic         axi3_rvalid_o,
    input  logic         axi3_rready_i,
    output logic [7:0]   axi3_rid_o,
    output logic [255:0] axi3_rdata_o,
    output logic [1:0]   axi3_rresp_o,
    output logic         axi3_rlast_o,
    input  logic         axi3_awvalid_i,
    output logic         axi3_awready_o,
    input  logic [31:0]  axi3_awaddr_i,
    input  logic [3:0]   axi3_awlen_i,
    input  logic [2:0]   axi3_awsize_i,
    input  logic [1:0]   axi3_awburst_i,
    input  logic [7:0]   axi3_wid_i,
    input  logic         axi3_wvalid_i,
    output logic         axi3_wready_o,
    input  logic [255:0] axi3_wdata_i,
    input  logic [31:0]  axi3_wstrb_i,
    input  logic         axi3_wlast_i,
    output logic         axi3_bvalid_o,
    input  logic         axi3_bready_i,
    output logic [7:0]   axi3_bid_o,
    output logic [1:0]   axi3_bresp_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t                  state;
    logic                    pri_wr;
    logic                    err;
    logic                    incr;
    logic                    over;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [3:0]              len;
    logic [3:0]              cnt;
    logic [255:0]            mem [DEPTH];

    logic                    ar_hs, aw_hs, r_hs, w_hs;
    logic                    ar_err, aw_err;
    logic [DEPTH_LOG2-1:0]   ar_idx, aw_idx, idx_next;
    logic                    unused_bits;

    function automatic logic [255:0] merge_bytes(input logic [255:0] old,
                                                 input logic [255:0] data,
                                                 input logic [31:0]  strb);
        logic [255:0] res;
        res = old;
        for (int b = 0; b < 32; b++) begin
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        end
        return res;
    endfunction

    // Grants are gated by reset so nothing is offered while the block is held.
    assign axi3_arready_o = rst_i && (state == IDLE) && axi3_arvalid_i
                            && !(axi3_awvalid_i && pri_wr);
    assign axi3_awready_o = rst_i && (state == IDLE) && axi3_awvalid_i
                            && !(axi3_arvalid_i && !pri_wr);
    assign axi3_wready_o  = (state == WR);

    assign ar_hs    = axi3_arvalid_i && axi3_arready_o;
    assign aw_hs    = axi3_awvalid_i && axi3_awready_o;
    assign r_hs     = axi3_rvalid_o && axi3_rready_i;
    assign w_hs     = axi3_wvalid_i && axi3_wready_o;
    assign ar_err   = axi3_arburst_i[1] || (axi3_arsize_i != 3'b101);
    assign aw_err   = axi3_awburst_i[1] || (axi3_awsize_i != 3'b101);
    assign ar_idx   = axi3_araddr_i[DEPTH_LOG2+4:5];
    assign aw_idx   = axi3_awaddr_i[DEPTH_LOG2+4:5];
    assign idx_next = incr ? idx + DEPTH_LOG2'(1) : idx;

    assign unused_bits = ^{axi3_araddr_i[31:DEPTH_LOG2+5], axi3_araddr_i[4:0],
                           axi3_awaddr_i[31:DEPTH_LOG2+5], axi3_awaddr_i[4:0]};

    // Beats past len+1 (over) and error bursts never touch the array.
    always_ff @(posedge clk_i) begin
        if (w_hs && !err && !over) mem[idx] <= merge_bytes(mem[idx], axi3_wdata_i, axi3_wstrb_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            pri_wr        <= 1'b0;
            err           <= 1'b0;
            incr          <= 1'b0;
            over          <= 1'b0;
            idx           <= '0;
            len           <= '0;
            cnt           <= '0;
            axi3_rvalid_o <= 1'b0;
            axi3_rlast_o  <= 1'b0;
            axi3_rid_o    <= '0;
            axi3_rresp_o  <= RESP_OKAY;
            axi3_rdata_o  <= '0;
            axi3_bvalid_o <= 1'b0;
            axi3_bid_o    <= '0;
            axi3_bresp_o  <= RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        state         <= RD;
                        pri_wr        <= 1'b1;
                        axi3_rid_o    <= axi3_arid_i;
                        idx           <= ar_idx;
                        len           <= axi3_arlen_i;
                        err           <= ar_err;
                        incr          <= (axi3_arburst_i == 2'b01);
                        cnt           <= '0;
                        axi3_rvalid_o <= 1'b1;
                        axi3_rlast_o  <= (axi3_arlen_i == 4'd0);
                        axi3_rresp_o  <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        axi3_rdata_o  <= ar_err ? RD_ERR_DATA : mem[ar_idx];
                    end else if (aw_hs) begin
                        state  <= WR;
                        pri_wr <= 1'b0;
                        idx    <= aw_idx;
                        len    <= axi3_awlen_i;
                        err    <= aw_err;
                        incr   <= (axi3_awburst_i == 2'b01);
                        cnt    <= '0;
                        over   <= 1'b0;
                    end
                end
                RD: begin
                    if (r_hs) begin
                        if (axi3_rlast_o) begin
                            state         <= IDLE;
                            axi3_rvalid_o <= 1'b0;
                            axi3_rlast_o  <= 1'b0;
                            cnt           <= '0;
                        end else begin
                            cnt          <= cnt + 4'd1;
                            idx          <= idx_next;
                            axi3_rlast_o <= ((cnt + 4'd1) == len);
                            axi3_rdata_o <= err ? RD_ERR_DATA : mem[idx_next];
                        end
                    end
                end
                WR: begin
                    if (w_hs) begin
                        if (cnt == 4'd0 && !over) axi3_bid_o <= axi3_wid_i;
                        if (axi3_wlast_i) begin
                            state         <= WRESP;
                            axi3_bvalid_o <= 1'b1;
                            axi3_bresp_o  <= (err || over || cnt != len) ? RESP_SLVERR : RESP_OKAY;
                            cnt           <= '0;
                        end else begin
                            idx <= idx_next;
                            if (cnt == len) over <= 1'b1;
                            else            cnt  <= cnt + 4'd1;
                        end
                    end
                end
                WRESP: begin
                    if (axi3_bready_i) begin
                        state         <= IDLE;
                        axi3_bvalid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi3_mem_responder.sv
// Directed bench for axi3_mem_responder: a memory model and R/B expectation
// queues are filled as bursts are issued and drained as the DUT responds.
module tb_axi3_mem_responder;
    localparam logic [255:0] ERR_DATA = {8{32'hDEAD_BEEF}};

    typedef struct packed {
        logic [255:0] data;
        logic [7:0]   id;
        logic [1:0]   resp;
        logic         last;
    } rbeat_t;

    typedef struct packed {
        logic [7:0] id;
        logic [1:0] resp;
    } bresp_t;

    logic         clk_i = 1'b0, rst_i = 1'b0;
    logic         arvalid = 1'b0, arready;
    logic [7:0]   arid = '0;
    logic [31:0]  araddr = '0;
    logic [2:0]   arsize = '0;
    logic [3:0]   arlen = '0;
    logic [1:0]   arburst = '0;
    logic         rvalid, rready = 1'b0, rlast;
    logic [7:0]   rid;
    logic [255:0] rdata;
    logic [1:0]   rresp;
    logic         awvalid = 1'b0, awready;
    logic [31:0]  awaddr = '0;
    logic [3:0]   awlen = '0;
    logic [2:0]   awsize = '0;
    logic [1:0]   awburst = '0;
    logic [7:0]   wid = '0;
    logic         wvalid = 1'b0, wready, wlast = 1'b0;
    logic [255:0] wdata = '0;
    logic [31:0]  wstrb = '0;
    logic         bvalid, bready = 1'b0;
    logic [7:0]   bid;
    logic [1:0]   bresp;

    int           vectors = 0, miscompares = 0;
    logic [255:0] model [256];
    logic [255:0] wbuf [16];
    rbeat_t       rq[$];
    bresp_t       bq[$];
    logic [7:0]   cur_base;
    int           cur_len;
    logic         cur_incr, cur_err;
    logic         aw_rdy_at_ar;
    int           waits, waits2;

    axi3_mem_responder #(.DEPTH_LOG2(8), .RD_ERR_DATA(ERR_DATA)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .axi3_arvalid_i(arvalid), .axi3_arready_o(arready), .axi3_arid_i(arid),
        .axi3_araddr_i(araddr), .axi3_arsize_i(arsize), .axi3_arlen_i(arlen),
        .axi3_arburst_i(arburst), .axi3_rvalid_o(rvalid), .axi3_rready_i(rready),
        .axi3_rid_o(rid), .axi3_rdata_o(rdata), .axi3_rresp_o(rresp), .axi3_rlast_o(rlast),
        .axi3_awvalid_i(awvalid), .axi3_awready_o(awready), .axi3_awaddr_i(awaddr),
        .axi3_awlen_i(awlen), .axi3_awsize_i(awsize), .axi3_awburst_i(awburst),
        .axi3_wid_i(wid), .axi3_wvalid_i(wvalid), .axi3_wready_o(wready),
        .axi3_wdata_i(wdata), .axi3_wstrb_i(wstrb), .axi3_wlast_i(wlast),
        .axi3_bvalid_o(bvalid), .axi3_bready_i(bready), .axi3_bid_o(bid), .axi3_bresp_o(bresp)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] id, output int w);
        logic       err, seen;
        logic [7:0] i8;
        rbeat_t     e;
        araddr = addr; arlen = len; arburst = burst; arsize = size; arid = id; arvalid = 1'b1;
        w = 0; seen = 1'b0;
        while (!seen && w < 20) begin
            @(negedge clk_i);
            if (arready) seen = 1'b1;
            else w++;
            if (seen) aw_rdy_at_ar = awready;
            @(posedge clk_i); #1;
        end
        arvalid = 1'b0;
        check("ar_accept", seen, 1'b1);
        err = burst[1] || (size != 3'b101);
        for (int k = 0; k <= int'(len); k++) begin
            i8 = addr[12:5] + ((burst == 2'b01) ? 8'(k) : 8'd0);
            e.data = err ? ERR_DATA : model[i8];
            e.id   = id;
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (k == int'(len));
            rq.push_back(e);
        end
    endtask

    // pat gives rready per cycle; rready=0 cycles check that the pending beat is held.
    task automatic recv_r(input int n, input logic [31:0] pat, output int w);
        int     got, cyc;
        rbeat_t e;
        got = 0; cyc = 0; w = 0;
        while (got < n && cyc < 64) begin
            rready = pat[cyc % 32];
            @(negedge clk_i);
            if (rvalid) begin
                if (rq.size() == 0) begin
                    check("r_unexpected", rvalid, 1'b0);
                end else begin
                    e = rq[0];
                    check(rready ? "rdata" : "rdata_hold", rdata, e.data);
                    check(rready ? "rlast" : "rlast_hold", rlast, e.last);
                    check("rid", rid, e.id);
                    check("rresp", rresp, e.resp);
                    if (rready) begin
                        void'(rq.pop_front());
                        got++;
                    end
                end
            end else begin
                w++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        rready = 1'b0;
        check("r_beats", got, n);
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, output int w);
        logic seen;
        awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
        w = 0; seen = 1'b0;
        while (!seen && w < 20) begin
            @(negedge clk_i);
            if (awready) seen = 1'b1;
            else w++;
            @(posedge clk_i); #1;
        end
        awvalid = 1'b0;
        check("aw_accept", seen, 1'b1);
        cur_base = addr[12:5];
        cur_len  = int'(len);
        cur_incr = (burst == 2'b01);
        cur_err  = burst[1] || (size != 3'b101);
    endtask

    task automatic send_w(input int nbeats, input logic [7:0] id, input logic [31:0] strb);
        logic [7:0] i8;
        logic       seen;
        int         t;
        bresp_t     b;
        for (int k = 0; k < nbeats; k++) begin
            wvalid = 1'b1; wdata = wbuf[k]; wstrb = strb; wid = id + 8'(k);
            wlast = (k == nbeats - 1);
            seen = 1'b0; t = 0;
            while (!seen && t < 20) begin
                @(negedge clk_i);
                if (wready) seen = 1'b1;
                else t++;
                @(posedge clk_i); #1;
            end
            check("w_accept", seen, 1'b1);
            if (!cur_err && k <= cur_len) begin
                i8 = cur_base + (cur_incr ? 8'(k) : 8'd0);
                for (int bb = 0; bb < 32; bb++)
                    if (strb[bb]) model[i8][bb*8 +: 8] = wbuf[k][bb*8 +: 8];
            end
        end
        wvalid = 1'b0; wlast = 1'b0;
        b.id   = id;
        b.resp = (cur_err || nbeats != cur_len + 1) ? 2'b10 : 2'b00;
        bq.push_back(b);
    endtask

    task automatic recv_b(output int w);
        logic   seen;
        bresp_t e;
        bready = 1'b1; seen = 1'b0; w = 0;
        while (!seen && w < 20) begin
            @(negedge clk_i);
            if (bvalid) begin
                seen = 1'b1;
                e = bq.pop_front();
                check("bid", bid, e.id);
                check("bresp", bresp, e.resp);
            end else begin
                w++;
            end
            @(posedge clk_i); #1;
        end
        bready = 1'b0;
        check("b_seen", seen, 1'b1);
    endtask

    initial begin
        // Reset held with random inputs: every response output must stay quiet.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            arvalid = 1'($urandom); awvalid = 1'($urandom); wvalid = 1'($urandom);
            rready = 1'($urandom); bready = 1'($urandom); wlast = 1'($urandom);
            araddr = $urandom; awaddr = $urandom; arid = 8'($urandom); wid = 8'($urandom);
            @(negedge clk_i);
            check("rst_handshake", {arready, awready, wready, rvalid, rlast, bvalid}, 6'd0);
            check("rst_ids", {rid, bid, rresp, bresp}, 20'd0);
            check("rst_rdata", rdata, 256'd0);
        end
        @(posedge clk_i); #1;
        awvalid = 0; wvalid = 0; rready = 0; bready = 0; wlast = 0; arvalid = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b1; #1;
        check("arready_on_release", {arready, awready}, 2'b10);
        arvalid = 1'b0;
        @(posedge clk_i); #1;

        // INCR write of four beats at word 2, then read back.
        for (int k = 0; k < 16; k++) wbuf[k] = {8{$urandom}};
        send_aw(32'h40, 4'd3, 2'b01, 3'b101, waits);
        send_w(4, 8'h5A, 32'hFFFF_FFFF);
        recv_b(waits);
        check("bvalid_latency", waits, 0);
        send_ar(32'h40, 4'd3, 2'b01, 3'b101, 8'h11, waits);
        check("ar_wait", waits, 0);
        recv_r(4, 32'hFFFF_FFFF, waits);
        check("r_back_to_back", waits, 0);

        // Full-strobe init of word 1, then FIXED partial-strobe burst over it.
        wbuf[0] = {8{32'h1234_5678}};
        send_aw(32'h20, 4'd0, 2'b01, 3'b101, waits);
        send_w(1, 8'h01, 32'hFFFF_FFFF);
        recv_b(waits);
        wbuf[0] = {8{32'hAAAA_0001}}; wbuf[1] = {8{32'hBBBB_0002}};
        send_aw(32'h20, 4'd1, 2'b00, 3'b101, waits);
        send_w(2, 8'h02, 32'h0000_000F);
        recv_b(waits);
        send_ar(32'h8000_0020, 4'd0, 2'b01, 3'b101, 8'h12, waits);
        recv_r(1, 32'hFFFF_FFFF, waits);
        check("fixed_word1", model[1], {{7{32'h1234_5678}}, 32'hBBBB_0002});

        // Wrap at the top of memory, with rready backpressure on the read.
        wbuf[0] = {8{32'hC0DE_00FF}}; wbuf[1] = {8{32'hC0DE_0000}};
        send_aw(32'h1FE0, 4'd1, 2'b01, 3'b101, waits);
        send_w(2, 8'h03, 32'hFFFF_FFFF);
        recv_b(waits);
        send_ar(32'h1FE0, 4'd1, 2'b01, 3'b101, 8'h22, waits);
        recv_r(2, 32'b0_1011_0100, waits);

        // Error reads: bad size, WRAP burst.
        send_ar(32'h40, 4'd1, 2'b01, 3'b100, 8'h33, waits);
        recv_r(2, 32'hFFFF_FFFF, waits);
        send_ar(32'h40, 4'd2, 2'b10, 3'b101, 8'h34, waits);
        recv_r(3, 32'hFFFF_FFFF, waits);

        // Early wlast, then a beat overrun past len+1.
        for (int k = 0; k < 4; k++) wbuf[k] = {8{$urandom}};
        send_aw(32'h140, 4'd3, 2'b01, 3'b101, waits);
        send_w(2, 8'h44, 32'hFFFF_FFFF);
        recv_b(waits);
        send_aw(32'h180, 4'd1, 2'b01, 3'b101, waits);
        send_w(2, 8'h45, 32'hFFFF_FFFF);
        recv_b(waits);
        for (int k = 0; k < 3; k++) wbuf[k] = {8{$urandom}};
        send_aw(32'h180, 4'd0, 2'b01, 3'b101, waits);
        send_w(3, 8'h46, 32'hFFFF_FFFF);
        recv_b(waits);
        send_ar(32'h140, 4'd1, 2'b01, 3'b101, 8'h47, waits);
        recv_r(2, 32'hFFFF_FFFF, waits);
        send_ar(32'h180, 4'd1, 2'b01, 3'b101, 8'h48, waits);
        recv_r(2, 32'hFFFF_FFFF, waits);

        // Error-size write must not modify memory.
        wbuf[0] = '1;
        send_aw(32'h40, 4'd0, 2'b01, 3'b011, waits);
        send_w(1, 8'h50, 32'hFFFF_FFFF);
        recv_b(waits);

        // Simultaneous AR/AW after a write: read wins, write follows immediately.
        wbuf[0] = {8{32'h0F0F_5555}};
        awaddr = 32'h280; awlen = 4'd0; awburst = 2'b01; awsize = 3'b101; awvalid = 1'b1;
        send_ar(32'h40, 4'd0, 2'b01, 3'b101, 8'h60, waits);
        check("arb_read_first", aw_rdy_at_ar, 1'b0);
        recv_r(1, 32'hFFFF_FFFF, waits);
        send_aw(32'h280, 4'd0, 2'b01, 3'b101, waits2);
        check("aw_after_r", waits2, 0);
        send_w(1, 8'h61, 32'hFFFF_FFFF);
        recv_b(waits);

        // Reset in the middle of a FIXED read burst.
        send_ar(32'h40, 4'd7, 2'b00, 3'b101, 8'h70, waits);
        recv_r(2, 32'hFFFF_FFFF, waits);
        rready = 1'b1;
        rst_i = 1'b0; #1;
        check("midrst_rvalid", {rvalid, rlast}, 2'b00);
        rq.delete();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_quiet", {rvalid, bvalid, wready}, 3'b000);
        @(posedge clk_i); #1;
        rready = 1'b0;
        send_ar(32'h280, 4'd0, 2'b01, 3'b101, 8'h71, waits);
        recv_r(1, 32'hFFFF_FFFF, waits);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
